temporal_ngram_encoder: RTL and testbench

Builds temporal N-gram hypervectors from the stream of fused spatial hypervectors, one per sample window. It sits between the spatial fusion/encoding stage and the associative memory. It consumes one spatially fused HV per sample period and emits the bound N-gram HV that the associative memory classifies. The block keeps the last NGRAM_SIZE-1 accepted HVs, and uses valid/ready handshakes on both sides.

---
 rtl/hdc_pkg.sv | 50 +++++
 rtl/temporal_ngram_encoder_if.sv | 50 +++++
 rtl/hv_ngram_bind.sv | 58 +++++
 rtl/temporal_ngram_encoder.sv | 178 +++++++++++++++++
 tb/tb_temporal_ngram_encoder.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hdc_pkg.sv
// -----------------------------------------------------------------------------
// hdc_pkg
//
// Shared definitions for the hyperdimensional-computing pipeline.
//   HV_DIMENSION   hypervector width, taken from the `HV_DIMENSION macro
//                  (default 2000 when the macro is not defined elsewhere).
//   NGRAM_SIZE     default number of samples bound into one temporal N-gram.
//   hv_t           one hypervector of HV_DIMENSION bits.
//   ceil_log2()    bits needed to hold the values 0 .. value-1.
//   permute()      rho^k: rotate a full-width hypervector left by k positions.
// -----------------------------------------------------------------------------
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif

package hdc_pkg;

    localparam int HV_DIMENSION   = `HV_DIMENSION;
    localparam int NGRAM_SIZE     = 3;
    localparam int NGRAM_SIZE_MAX = 8;

    typedef logic [HV_DIMENSION-1:0] hv_t;

    // Smallest r with 2**r >= value; used to size counters that must hold
    // 0 .. value-1.
    function automatic int ceil_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // rho^k. k never exceeds NGRAM_SIZE_MAX-1 in this pipeline, so the loop
    // bound is fixed and the function unrolls to plain wiring.
    function automatic hv_t permute(input hv_t x, input int unsigned k);
        hv_t result;
        result = x;
        for (int unsigned i = 0; i < NGRAM_SIZE_MAX; i++) begin
            if (i < k) begin
                result = {result[HV_DIMENSION-2:0], result[HV_DIMENSION-1]};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/temporal_ngram_encoder_if.sv
// -----------------------------------------------------------------------------
// temporal_ngram_encoder_if
//
// Stream bundle around the temporal N-gram encoder: spatial hypervectors come
// in on the hvin channel, bound N-grams leave on the hvout channel. Both are
// valid/ready handshakes; a transfer happens on a clock edge where valid and
// ready are both high.
//
// Signals
//   hvin_valid   upstream has a spatial HV on hvin
//   hvin_ready   encoder accepts hvin this cycle
//   hvin         spatial HV for the current sample window
//   hvout_valid  encoder holds an N-gram on hvout (held until accepted)
//   hvout_ready  downstream (associative memory) accepts hvout
//   hvout        bound N-gram HV
//
// Modports
//   slave   the encoder side
//   master  the side that feeds hvin and drains hvout
// -----------------------------------------------------------------------------
interface temporal_ngram_encoder_if #(
    parameter int HV_DIMENSION = hdc_pkg::HV_DIMENSION
);

    logic                    hvin_valid;
    logic                    hvin_ready;
    logic [HV_DIMENSION-1:0] hvin;
    logic                    hvout_valid;
    logic                    hvout_ready;
    logic [HV_DIMENSION-1:0] hvout;

    modport slave (
        input  hvin_valid,
        input  hvin,
        input  hvout_ready,
        output hvin_ready,
        output hvout_valid,
        output hvout
    );

    modport master (
        output hvin_valid,
        output hvin,
        output hvout_ready,
        input  hvin_ready,
        input  hvout_valid,
        input  hvout
    );

endinterface

// File: rtl/hv_ngram_bind.sv
// -----------------------------------------------------------------------------
// hv_ngram_bind
//
// Purely combinational N-gram binding:
//   o_ngram = i_hvin ^ rho(h[0]) ^ rho^2(h[1]) ^ ... ^ rho^(N-1)(h[N-2])
// where rho is a rotate-left by one bit and h[0] is the most recent history
// entry. Each rotation is fixed wiring, so the cost is one XOR tree per bit.
//
// Parameters
//   HV_DIMENSION  hypervector width
//   NGRAM_SIZE    samples per N-gram (1..8); with 1 the history is ignored
//
// Ports
//   i_hvin   current spatial HV
//   i_hist   history, entry k holds the sample accepted k+1 fires ago
//   o_ngram  bound N-gram
// -----------------------------------------------------------------------------
module hv_ngram_bind #(
    parameter int  HV_DIMENSION = hdc_pkg::HV_DIMENSION,
    parameter int  NGRAM_SIZE   = hdc_pkg::NGRAM_SIZE,
    localparam int HIST_DEPTH   = (NGRAM_SIZE > 1) ? NGRAM_SIZE - 1 : 1
) (
    input  logic [HIST_DEPTH-1:0][HV_DIMENSION-1:0] i_hist,
    input  logic [HV_DIMENSION-1:0]                 i_hvin,
    output logic [HV_DIMENSION-1:0]                 o_ngram
);

    // Single-step rho; the MSB wraps into bit 0.
    function automatic logic [HV_DIMENSION-1:0] rho(input logic [HV_DIMENSION-1:0] x);
        return {x[HV_DIMENSION-2:0], x[HV_DIMENSION-1]};
    endfunction

    generate
        if (NGRAM_SIZE == 1) begin : g_passthru
            // No history: the N-gram is the sample itself.
            logic w_unused_hist;
            assign w_unused_hist = ^i_hist;
            assign o_ngram       = i_hvin;
        end else begin : g_bind
            always_comb begin
                logic [HV_DIMENSION-1:0] w_acc;
                logic [HV_DIMENSION-1:0] w_term;
                w_acc  = i_hvin;
                w_term = '0;
                for (int k = 0; k < HIST_DEPTH; k++) begin
                    // Older samples are rotated further: h[k] gets rho^(k+1).
                    w_term = i_hist[k];
                    for (int r = 0; r <= k; r++) begin
                        w_term = rho(w_term);
                    end
                    w_acc = w_acc ^ w_term;
                end
                o_ngram = w_acc;
            end
        end
    endgenerate

endmodule

// File: rtl/temporal_ngram_encoder.sv
// -----------------------------------------------------------------------------
// temporal_ngram_encoder
//
// Turns the stream of spatially fused hypervectors (one per sample window)
// into temporal N-gram hypervectors for the associative memory. The block keeps
// the last NGRAM_SIZE-1 accepted samples, binds them with the incoming sample
// (hv_ngram_bind) and registers the result on acceptance.
//
// Warm-up: the first NGRAM_SIZE-1 accepted samples only fill the history and
// produce no output. The fire that brings the fill counter to NGRAM_SIZE is
// the first one to produce an N-gram.
//
// Build option
//   TEMPORAL_TUMBLING_EN  defined: tumbling windows. Every producing fire
//                         clears the fill counter and the history, so one
//                         N-gram is emitted per NGRAM_SIZE samples with no
//                         overlap.
//                         undefined (default): sliding window. After warm-up
//                         every accepted sample produces an N-gram.
//
// Parameters
//   HV_DIMENSION  hypervector width in bits
//   NGRAM_SIZE    samples per N-gram, 1..8
//
// Ports
//   clk   sole clock, all state changes on its rising edge
//   rst   asynchronous, active-low reset
//   bus   stream bundle (slave side): hvin_valid/hvin_ready/hvin in,
//         hvout_valid/hvout_ready/hvout out
// -----------------------------------------------------------------------------
module temporal_ngram_encoder #(
    parameter int HV_DIMENSION = hdc_pkg::HV_DIMENSION,
    parameter int NGRAM_SIZE   = hdc_pkg::NGRAM_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    temporal_ngram_encoder_if.slave bus
);

    localparam int FILL_W     = hdc_pkg::ceil_log2(NGRAM_SIZE + 1);
    localparam int HIST_DEPTH = (NGRAM_SIZE > 1) ? NGRAM_SIZE - 1 : 1;

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NGRAM_SIZE);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(NGRAM_SIZE - 1);

    generate
        if (NGRAM_SIZE < 1 || NGRAM_SIZE > hdc_pkg::NGRAM_SIZE_MAX) begin : g_bad_ngram_size
            $error("temporal_ngram_encoder: NGRAM_SIZE must be in 1..8");
        end
    endgenerate

    // ---------------------------------------------------------------- state
    logic [FILL_W-1:0]       r_fill;
    logic [FILL_W-1:0]       w_fill_next;
    logic [HV_DIMENSION-1:0] r_hvout;
    logic                    r_hvout_valid;

    // ------------------------------------------------------------ handshake
    logic                    w_hvin_ready;
    logic                    w_hvin_fire;
    logic                    w_hvout_fire;
    logic                    w_produce;

    logic [HIST_DEPTH-1:0][HV_DIMENSION-1:0] w_hist;
    logic [HV_DIMENSION-1:0]                 w_ngram;

    // A new sample may enter whenever the output register is empty or is
    // being drained this very cycle, which keeps full throughput with
    // hvout_ready held high and freezes everything under backpressure.
    assign w_hvin_ready = ~r_hvout_valid | bus.hvout_ready;
    assign w_hvin_fire  = bus.hvin_valid & w_hvin_ready;
    assign w_hvout_fire = r_hvout_valid & bus.hvout_ready;

    // The fire that lands on the last warm-up slot produces. In sliding mode
    // the counter saturates at NGRAM_SIZE, so every later fire also produces.
    assign w_produce = w_hvin_fire & (r_fill >= FILL_LAST);

    assign bus.hvin_ready  = w_hvin_ready;
    assign bus.hvout_valid = r_hvout_valid;
    assign bus.hvout       = r_hvout;

    // --------------------------------------------------------- fill counter
    always_comb begin
        // NOTE: every variable written in a combinational block gets a value
        // on entry; a path that leaves one unassigned infers a latch.
        w_fill_next = r_fill;
        if (w_hvin_fire) begin
`ifdef TEMPORAL_TUMBLING_EN
            if (w_produce) begin
                w_fill_next = '0;
            end else begin
                w_fill_next = r_fill + 1'b1;
            end
`else
            if (r_fill != FILL_FULL) begin
                w_fill_next = r_fill + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst) begin
            r_fill <= '0;
        end else begin
            r_fill <= w_fill_next;
        end
    end

    // -------------------------------------------------------------- history
    generate
        if (NGRAM_SIZE > 1) begin : g_hist
            logic [HIST_DEPTH-1:0][HV_DIMENSION-1:0] r_hist;
            logic [HIST_DEPTH-1:0][HV_DIMENSION-1:0] w_hist_next;

            always_comb begin
                w_hist_next = r_hist;
                if (w_hvin_fire) begin
                    w_hist_next[0] = bus.hvin;
                    for (int k = 1; k < HIST_DEPTH; k++) begin
                        w_hist_next[k] = r_hist[k-1];
                    end
`ifdef TEMPORAL_TUMBLING_EN
                    if (w_produce) begin
                        w_hist_next = '0;
                    end
`endif
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                // NOTE: the history is cleared on reset even though it is a
                // register array: a restarted stream must bind against zeros,
                // not against samples from before the reset.
                if (!rst) begin
                    r_hist <= '0;
                end else begin
                    r_hist <= w_hist_next;
                end
            end

            assign w_hist = r_hist;
        end else begin : g_no_hist
            assign w_hist = '0;
        end
    endgenerate

    // -------------------------------------------------------------- binding
    hv_ngram_bind #(
        .HV_DIMENSION (HV_DIMENSION),
        .NGRAM_SIZE   (NGRAM_SIZE)
    ) u_bind (
        .i_hist  (w_hist),
        .i_hvin  (bus.hvin),
        .o_ngram (w_ngram)
    );

    // ------------------------------------------------------ output register
    // hvout only reloads on a producing fire, so it stays put while stalled
    // and also keeps its old value when a warm-up fire coincides with the
    // output being drained.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hvout       <= '0;
            r_hvout_valid <= 1'b0;
        end else begin
            if (w_produce) begin
                r_hvout <= w_ngram;
            end
            // A producing fire wins over a simultaneous drain, so
            // back-to-back N-grams keep hvout_valid high.
            r_hvout_valid <= w_produce | (r_hvout_valid & ~w_hvout_fire);
        end
    end

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// -----------------------------------------------------------------------------
// tb_temporal_ngram_encoder
//
// Self-checking bench for temporal_ngram_encoder with 16-bit hypervectors.
// u_dut3 (NGRAM_SIZE=3) carries the main stream; u_dut2 (NGRAM_SIZE=2) is used
// for the rotate wrap-around case. Expected N-grams for u_dut3 are pushed to a
// scoreboard queue when the producing sample is driven and are popped by a
// monitor whenever an hvout transfer happens. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
// Build with TEMPORAL_TUMBLING_EN defined to run the tumbling-window stream.
// -----------------------------------------------------------------------------
module tb_temporal_ngram_encoder;

    localparam int D = 16;

    typedef logic [D-1:0] tb_hv_t;

    typedef struct {
        tb_hv_t hvin;
        logic   produces;
        tb_hv_t expected;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    temporal_ngram_encoder_if #(.HV_DIMENSION(D)) b3 ();
    temporal_ngram_encoder_if #(.HV_DIMENSION(D)) b2 ();

    temporal_ngram_encoder #(
        .HV_DIMENSION (D),
        .NGRAM_SIZE   (3)
    ) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3)
    );

    temporal_ngram_encoder #(
        .HV_DIMENSION (D),
        .NGRAM_SIZE   (2)
    ) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    int     n_out3   = 0;
    tb_hv_t sb_q[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic drive3(input logic v, input tb_hv_t x, input logic rdy);
        b3.hvin_valid  = v;
        b3.hvin        = x;
        b3.hvout_ready = rdy;
    endtask

    task automatic drive2(input logic v, input tb_hv_t x, input logic rdy);
        b2.hvin_valid  = v;
        b2.hvin        = x;
        b2.hvout_ready = rdy;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every hvout transfer of u_dut3 must match the oldest
    // expected N-gram; a transfer with nothing expected is a failure.
    always @(negedge clk) begin
        if (rst && b3.hvout_valid && b3.hvout_ready) begin
            n_out3++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got output %h, expected no output (t=%0t)", b3.hvout, $time);
            end else begin
                check("sb_hvout", b3.hvout, sb_q.pop_front());
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t slide_tab[5];
        vec_t tumble_tab[6];
        int   out_before;

        // Sliding continuation after A,B,C,D (history h0=D=0x0020, h1=C=0).
        slide_tab[0] = '{16'h8001, 1'b1, 16'h8041};
        slide_tab[1] = '{16'h0000, 1'b1, 16'h0083};
        slide_tab[2] = '{16'hFFFF, 1'b1, 16'hFFF9};
        slide_tab[3] = '{16'h1234, 1'b1, 16'hEDCB};
        slide_tab[4] = '{16'h0000, 1'b1, 16'hDB97};

        // Tumbling, fresh after reset: outputs only after samples 3 and 6.
        tumble_tab[0] = '{16'h0001, 1'b0, 16'h0000};
        tumble_tab[1] = '{16'h0002, 1'b0, 16'h0000};
        tumble_tab[2] = '{16'h0004, 1'b1, 16'h0004};
        tumble_tab[3] = '{16'h0008, 1'b0, 16'h0000};
        tumble_tab[4] = '{16'h0010, 1'b0, 16'h0000};
        tumble_tab[5] = '{16'h0020, 1'b1, 16'h0020};

        drive3(1'b0, '0, 1'b1);
        drive2(1'b0, '0, 1'b1);

        // ---------------------------------------------------- reset state
        #3;
        check("rst_valid3", b3.hvout_valid, 0);
        check("rst_hvout3", b3.hvout, 0);
        check("rst_ready3", b3.hvin_ready, 1);
        check("rst_valid2", b2.hvout_valid, 0);
        check("rst_hvout2", b2.hvout, 0);
        check("rst_ready2", b2.hvin_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // -------------------------------------- wrap-around, N=2 (u_dut2)
        drive2(1'b1, 16'h8000, 1'b1);
        next_edge();
        drive2(1'b1, 16'h0000, 1'b1);
        @(negedge clk);
        check("wrap_warm_noval", b2.hvout_valid, 0);
        next_edge();
        drive2(1'b0, '0, 1'b1);
        @(negedge clk);
        check("wrap_valid", b2.hvout_valid, 1);
        check("wrap_hvout", b2.hvout, 16'h0001);
        next_edge();

`ifndef TEMPORAL_TUMBLING_EN
        // ---------------------------------------------- warm-up, sliding
        drive3(1'b1, 16'h0001, 1'b1);                 // A
        @(negedge clk);
        check("warm_ready", b3.hvin_ready, 1);
        next_edge();
        drive3(1'b1, 16'h0001, 1'b1);                 // B
        @(negedge clk);
        check("warm_noval_a", b3.hvout_valid, 0);
        next_edge();
        sb_q.push_back(16'h0006);
        drive3(1'b1, 16'h0000, 1'b1);                 // C
        @(negedge clk);
        check("warm_noval_b", b3.hvout_valid, 0);
        next_edge();
        drive3(1'b0, '0, 1'b1);
        @(negedge clk);
        check("warm_valid_c", b3.hvout_valid, 1);
        next_edge();
        @(negedge clk);
        check("warm_pulse_c", b3.hvout_valid, 0);
        next_edge();

        // ------------------------------ sliding steady state, back-to-back
        sb_q.push_back(16'h0024);
        drive3(1'b1, 16'h0020, 1'b1);                 // D
        next_edge();
        for (int i = 0; i < 5; i++) begin
            if (slide_tab[i].produces) begin
                sb_q.push_back(slide_tab[i].expected);
            end
            drive3(1'b1, slide_tab[i].hvin, 1'b1);
            next_edge();
        end
        drive3(1'b0, '0, 1'b1);
        repeat (2) next_edge();
        check("slide_drained", sb_q.size(), 0);
        check("slide_out_count", n_out3, 7);

        // --------------------------------------------------- backpressure
        sb_q.push_back(16'h48D1);
        drive3(1'b1, 16'h0001, 1'b1);                 // J
        next_edge();
        drive3(1'b1, 16'h0100, 1'b0);                 // K offered, output stalled
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_ready_low", b3.hvin_ready, 0);
            check("bp_hvout_hold", b3.hvout, 16'h48D1);
            check("bp_valid_hold", b3.hvout_valid, 1);
            next_edge();
        end
        sb_q.push_back(16'h0102);
        drive3(1'b1, 16'h0100, 1'b1);
        @(negedge clk);
        check("bp_release_ready", b3.hvin_ready, 1);
        next_edge();
        drive3(1'b0, '0, 1'b1);
        @(negedge clk);
        check("bp_valid_stays", b3.hvout_valid, 1);
        next_edge();
        @(negedge clk);
        check("bp_drained", sb_q.size(), 0);
        next_edge();
`else
        // ----------------------------------------------- tumbling windows
        rst = 1'b0;
        #2;
        rst = 1'b1;
        next_edge();
        out_before = n_out3;
        for (int i = 0; i < 6; i++) begin
            if (tumble_tab[i].produces) begin
                sb_q.push_back(tumble_tab[i].expected);
            end
            drive3(1'b1, tumble_tab[i].hvin, 1'b1);
            next_edge();
        end
        drive3(1'b0, '0, 1'b1);
        repeat (2) next_edge();
        check("tumble_out_count", n_out3 - out_before, 2);
        check("tumble_drained", sb_q.size(), 0);
`endif

        // ------------------------- async reset while an output is pending
        rst = 1'b0;
        #2;
        rst = 1'b1;
        next_edge();
        drive3(1'b1, 16'h0001, 1'b0);
        next_edge();
        drive3(1'b1, 16'h0001, 1'b0);
        next_edge();
        drive3(1'b1, 16'h0010, 1'b0);
        next_edge();
        drive3(1'b0, '0, 1'b0);
        @(negedge clk);
        check("pend_valid", b3.hvout_valid, 1);
        check("pend_hvout", b3.hvout, 16'h0016);
        check("pend_ready", b3.hvin_ready, 0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", b3.hvout_valid, 0);
        check("arst_hvout", b3.hvout, 0);
        check("arst_ready", b3.hvin_ready, 1);
        next_edge();
        rst = 1'b1;

        // --------------------------------- async reset mid-warm-up
        drive3(1'b1, 16'h0001, 1'b1);
        next_edge();
        drive3(1'b1, 16'h0002, 1'b1);
        next_edge();
        drive3(1'b0, '0, 1'b1);
        @(negedge clk);
        check("mid_noval", b3.hvout_valid, 0);
        #2;
        rst = 1'b0;
        #1;
        check("mid_arst_valid", b3.hvout_valid, 0);
        check("mid_arst_hvout", b3.hvout, 0);
        next_edge();
        rst = 1'b1;

        // Warm-up restarts from zero: two silent samples, output on the third.
        drive3(1'b1, 16'h0001, 1'b1);
        next_edge();
        drive3(1'b1, 16'h0001, 1'b1);
        next_edge();
        sb_q.push_back(16'h000E);
        drive3(1'b1, 16'h0008, 1'b1);
        @(negedge clk);
        check("restart_noval", b3.hvout_valid, 0);
        next_edge();
        drive3(1'b0, '0, 1'b1);
        @(negedge clk);
        check("restart_valid", b3.hvout_valid, 1);
        next_edge();
        repeat (2) next_edge();
        check("final_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
